// File: rtl/xbar_pkg.sv
// Shared types and sel-word layout helpers for the 4x4 crossbar scheduler.
package xbar_pkg;

    localparam int PORTS = 4;
    localparam int PW    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONN = 2'd1,
        RLS  = 2'd2
    } rx_state_t;

    // LSB of the demux field of tx port tx inside the sel word
    function automatic int demux_lsb(input int tx);
        return (2 * PW) * tx;
    endfunction

    // LSB of the mux field of rx port rx inside the sel word
    function automatic int mux_lsb(input int rx);
        return (2 * PW) * rx + PW;
    endfunction

    function automatic logic [PW-1:0] dst_of(input logic [PW*PORTS-1:0] dst, input int tx);
        return dst[PW*tx +: PW];
    endfunction

endpackage

// File: rtl/xbar_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins (wrapping).
module rr_arbiter
    import xbar_pkg::*;
(
    input  logic [PORTS-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PORTS-1:0] gnt,
    output logic [PW-1:0]    idx,
    output logic             any_valid
);

    // Scan requesters starting at ptr; the first hit is the winner
    always_comb begin
        logic [PW-1:0] cand_s;
        gnt       = '0;
        idx       = '0;
        any_valid = 1'b0;
        cand_s    = '0;
        for (int k = 0; k < PORTS; k++) begin
            cand_s = ptr + PW'(k);
            if (!any_valid && req[cand_s]) begin
                any_valid   = 1'b1;
                idx         = cand_s;
                gnt[cand_s] = 1'b1;
            end else begin
                any_valid = any_valid;
            end
        end
    end

endmodule

// File: rtl/xbar_sched.sv
// Crossbar scheduler: per-rx round-robin FSMs with hold timeout, driving the
// switch sel word and registered grant/busy/preempt qualifiers.
module xbar_sched
    import xbar_pkg::*;
#(
    parameter int MAX_HOLD = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PORTS-1:0]     req_valid,
    input  logic [PW*PORTS-1:0]  req_dst,
    output logic [PORTS-1:0]     grant,
    output logic [4*PORTS-1:0]   sel,
    output logic [PORTS-1:0]     rx_busy,
    output logic [PORTS-1:0]     preempt
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    typedef logic [HW-1:0] hold_t;
    localparam hold_t HOLD_MAX = hold_t'(MAX_HOLD);

    rx_state_t        state_r   [PORTS];
    rx_state_t        state_s   [PORTS];
    logic [PW-1:0]    owner_r   [PORTS];
    logic [PW-1:0]    owner_s   [PORTS];
    logic [PW-1:0]    ptr_r     [PORTS];
    logic [PW-1:0]    ptr_s     [PORTS];
    hold_t            hold_r    [PORTS];
    hold_t            hold_s    [PORTS];
    logic [PORTS-1:0] cont_s    [PORTS];
    logic [PORTS-1:0] arb_gnt_s [PORTS];
    logic [PW-1:0]    arb_idx_s [PORTS];
    logic [PORTS-1:0] arb_any_s;
    logic [PORTS-1:0] grant_s;
    logic [PORTS-1:0] busy_s;
    logic [PORTS-1:0] preempt_s;
    logic [4*PORTS-1:0] sel_s;

    // Contenders per rx: ungranted tx ports requesting that rx
    always_comb begin
        for (int j = 0; j < PORTS; j++) begin
            cont_s[j] = '0;
            for (int i = 0; i < PORTS; i++) begin
                cont_s[j][i] = req_valid[i] && (dst_of(req_dst, i) == PW'(j)) && !grant[i];
            end
        end
    end

    for (genvar j = 0; j < PORTS; j++) begin : g_arb
        rr_arbiter u_arb (
            .req       (cont_s[j]),
            .ptr       (ptr_r[j]),
            .gnt       (arb_gnt_s[j]),
            .idx       (arb_idx_s[j]),
            .any_valid (arb_any_s[j])
        );
    end

    // Per-rx next state: arbitration, voluntary release, hold-timeout preemption
    always_comb begin
        preempt_s = '0;
        for (int j = 0; j < PORTS; j++) begin
            state_s[j] = state_r[j];
            owner_s[j] = owner_r[j];
            ptr_s[j]   = ptr_r[j];
            hold_s[j]  = hold_r[j];
            case (state_r[j])
                IDLE: begin
                    if (arb_any_s[j]) begin
                        state_s[j] = CONN;
                        owner_s[j] = arb_idx_s[j];
                        ptr_s[j]   = arb_idx_s[j] + PW'(1);
                        hold_s[j]  = '0;
                    end else begin
                        state_s[j] = IDLE;
                    end
                end
                CONN: begin
                    if (!req_valid[owner_r[j]] ||
                        (dst_of(req_dst, int'(owner_r[j])) != PW'(j))) begin
                        state_s[j] = IDLE;
                    end else if ((hold_r[j] == HOLD_MAX) && (|cont_s[j])) begin
                        state_s[j]            = RLS;
                        preempt_s[owner_r[j]] = 1'b1;
                    end else if (hold_r[j] != HOLD_MAX) begin
                        hold_s[j] = hold_r[j] + hold_t'(1'b1);
                    end else begin
                        hold_s[j] = hold_r[j];
                    end
                end
                RLS: begin
                    state_s[j] = IDLE;
                end
                default: begin
                    state_s[j] = IDLE;
                end
            endcase
        end
    end

    // Output assembly from the next connection set; fresh grants take the arbiter one-hot
    always_comb begin
        grant_s = '0;
        sel_s   = '0;
        busy_s  = '0;
        for (int j = 0; j < PORTS; j++) begin
            if (state_s[j] == CONN) begin
                if (state_r[j] == IDLE) begin
                    grant_s = grant_s | arb_gnt_s[j];
                end else begin
                    grant_s[owner_r[j]] = 1'b1;
                end
                sel_s[demux_lsb(int'(owner_s[j])) +: PW] = PW'(j);
                sel_s[mux_lsb(j) +: PW]                  = owner_s[j];
                busy_s[j]                                = 1'b1;
            end else begin
                busy_s[j] = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < PORTS; j++) begin
                state_r[j] <= IDLE;
                owner_r[j] <= '0;
                ptr_r[j]   <= '0;
                hold_r[j]  <= '0;
            end
            grant   <= '0;
            sel     <= '0;
            rx_busy <= '0;
            preempt <= '0;
        end else begin
            for (int j = 0; j < PORTS; j++) begin
                state_r[j] <= state_s[j];
                owner_r[j] <= owner_s[j];
                ptr_r[j]   <= ptr_s[j];
                hold_r[j]  <= hold_s[j];
            end
            grant   <= grant_s;
            sel     <= sel_s;
            rx_busy <= busy_s;
            preempt <= preempt_s;
        end
    end

endmodule

// File: tb/tb_xbar_sched.sv
// Scoreboard bench for xbar_sched: a connection-level reference model predicts
// each cycle's outputs into a queue; a monitor pops and compares after every edge.
module tb_xbar_sched;

    localparam int MAXH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [7:0]  req_dst;
    logic [3:0]  grant;
    logic [15:0] sel;
    logic [3:0]  rx_busy;
    logic [3:0]  preempt;

    typedef struct packed {
        logic [3:0]  g;
        logic [15:0] s;
        logic [3:0]  b;
        logic [3:0]  p;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: owner tx per rx (-1 = free), connection age, RR pointer, release cycle
    int own[4];
    int age[4];
    int ptr[4];
    bit rls[4];

    xbar_sched #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_dst   (req_dst),
        .grant     (grant),
        .sel       (sel),
        .rx_busy   (rx_busy),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Advance the reference model by one clock edge using the inputs just driven
    task automatic model_step();
        bit         busy_tx[4];
        logic [3:0] pre;
        exp_t       e;
        int         win, cnt, o, i;
        pre = 4'b0;
        if (rst) begin
            for (int j = 0; j < 4; j++) begin
                own[j] = -1; age[j] = 0; ptr[j] = 0; rls[j] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 4; k++) busy_tx[k] = 1'b0;
            for (int j = 0; j < 4; j++) if (own[j] >= 0) busy_tx[own[j]] = 1'b1;
            for (int j = 0; j < 4; j++) begin
                win = -1;
                cnt = 0;
                for (int k = 0; k < 4; k++) begin
                    i = (ptr[j] + k) % 4;
                    if (req_valid[i] && req_dst[2*i +: 2] == j && !busy_tx[i]) begin
                        cnt++;
                        if (win < 0) win = i;
                    end
                end
                if (rls[j]) begin
                    rls[j] = 1'b0;
                end else if (own[j] < 0) begin
                    if (win >= 0) begin
                        own[j] = win; ptr[j] = (win + 1) % 4; age[j] = 0;
                    end
                end else begin
                    o = own[j];
                    if (!req_valid[o] || req_dst[2*o +: 2] != j) begin
                        own[j] = -1;
                    end else if (age[j] == MAXH && cnt > 0) begin
                        pre[o] = 1'b1; own[j] = -1; rls[j] = 1'b1;
                    end else if (age[j] < MAXH) begin
                        age[j]++;
                    end
                end
            end
        end
        e = '0;
        e.p = pre;
        for (int j = 0; j < 4; j++) begin
            if (own[j] >= 0) begin
                e.g[own[j]]           = 1'b1;
                e.s[4*own[j] +: 2]    = 2'(j);
                e.s[4*j + 2 +: 2]     = 2'(own[j]);
                e.b[j]                = 1'b1;
            end
        end
        q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [7:0] d);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_dst   = d;
        model_step();
    endtask

    // Monitor: outputs are presented every cycle; compare against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb_grant",   {12'h000, grant},   {12'h000, e.g});
                check("sb_sel",     sel,                e.s);
                check("sb_rx_busy", {12'h000, rx_busy}, {12'h000, e.b});
                check("sb_preempt", {12'h000, preempt}, {12'h000, e.p});
            end
        end
    end

    initial begin
        logic [3:0] rv;
        logic [7:0] rd;
        rst = 1'b1; req_valid = 4'b0; req_dst = 8'h00;
        for (int j = 0; j < 4; j++) begin
            own[j] = -1; age[j] = 0; ptr[j] = 0; rls[j] = 1'b0;
        end

        // Reset, no requests
        drive(1'b1, 4'b0000, 8'h00);
        drive(1'b1, 4'b0000, 8'h00);
        drive(1'b0, 4'b0000, 8'h00);
        check("reset_grant", {12'h000, grant}, 16'h0000);
        check("reset_sel", sel, 16'h0000);
        check("reset_busy", {12'h000, rx_busy}, 16'h0000);

        // Single request tx0 -> rx2
        drive(1'b0, 4'b0001, 8'h02);
        drive(1'b0, 4'b0001, 8'h02);
        check("single_grant", {12'h000, grant}, 16'h0001);
        check("single_sel", sel, 16'h0002);
        check("single_busy", {12'h000, rx_busy}, 16'h0004);
        drive(1'b0, 4'b0000, 8'h00);
        drive(1'b0, 4'b0000, 8'h00);

        // Contention tx1, tx3 on rx0
        drive(1'b0, 4'b1010, 8'h00);
        drive(1'b0, 4'b1010, 8'h00);
        check("cont_first", {12'h000, grant}, 16'h0002);
        drive(1'b0, 4'b1000, 8'h00);
        drive(1'b0, 4'b1000, 8'h00);
        check("cont_bubble", {12'h000, grant}, 16'h0000);
        drive(1'b0, 4'b1010, 8'h00);
        check("cont_second", {12'h000, grant}, 16'h0008);
        drive(1'b0, 4'b1010, 8'h00);
        check("cont_wait", {12'h000, grant}, 16'h0008);
        for (int k = 0; k < 4; k++) drive(1'b0, 4'b0010, 8'h00);
        drive(1'b0, 4'b0000, 8'h00);
        drive(1'b0, 4'b0000, 8'h00);

        // Full permutation
        drive(1'b0, 4'b1111, 8'h1B);
        drive(1'b0, 4'b1111, 8'h1B);
        check("perm_grant", {12'h000, grant}, 16'h000F);
        check("perm_sel", sel, 16'h05AF);
        check("perm_busy", {12'h000, rx_busy}, 16'h000F);
        drive(1'b0, 4'b0000, 8'h00);
        drive(1'b0, 4'b0000, 8'h00);

        // Hold timeout: tx2 holds rx1, tx0 contends
        drive(1'b0, 4'b0100, 8'h10);
        for (int k = 0; k < 12; k++) drive(1'b0, 4'b0101, 8'h11);
        drive(1'b0, 4'b0000, 8'h00);
        drive(1'b0, 4'b0000, 8'h00);

        // Reset mid-operation, then a tie on rx1 goes to tx0
        drive(1'b0, 4'b0111, 8'h1B);
        drive(1'b0, 4'b0111, 8'h1B);
        drive(1'b1, 4'b0111, 8'h1B);
        drive(1'b0, 4'b0101, 8'h11);
        check("midrst_grant", {12'h000, grant}, 16'h0000);
        check("midrst_sel", sel, 16'h0000);
        drive(1'b0, 4'b0101, 8'h11);
        check("midrst_tie", {12'h000, grant}, 16'h0001);
        drive(1'b0, 4'b0000, 8'h00);

        // Randomized sticky requests with occasional reset
        rv = 4'b0;
        rd = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) rv[i] = ~rv[i];
                if ($urandom_range(0, 15) == 0) rd[2*i +: 2] = 2'($urandom_range(0, 3));
            end
            drive(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, rv, rd);
        end

        drive(1'b0, 4'b0000, 8'h00);
        @(posedge clk);
        #2;
        check("queue_drained", 16'(q.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
